// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - MMU request/response and decode handshake bundle for inst_fetch_unit
interface inst_fetch_unit_if;
   logic        FLUSH;
   logic [31:0] NEW_PC;
   logic        MEM_WAIT;
   logic        INST_RDEN;
   logic [31:0] INST_RIADDR;
   logic [31:0] INST_ROADDR;
   logic        INST_RVALID;
   logic [31:0] INST_RDATA;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] OUT_PC;
   logic [31:0] OUT_INST;

   modport master (
      output FLUSH, NEW_PC, MEM_WAIT, INST_ROADDR, INST_RVALID, INST_RDATA, OUT_READY,
      input  INST_RDEN, INST_RIADDR, OUT_VALID, OUT_PC, OUT_INST
   );

   modport slave (
      input  FLUSH, NEW_PC, MEM_WAIT, INST_ROADDR, INST_RVALID, INST_RDATA, OUT_READY,
      output INST_RDEN, INST_RIADDR, OUT_VALID, OUT_PC, OUT_INST
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - sequential instruction fetch with stale-response filter and output FIFO
// Optional FETCH_BYPASS_EN: zero-latency forwarding of a matching response when the FIFO is empty.
module inst_fetch_unit #(
   parameter logic [31:0] START_ADDR = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH  = 4
) (
   input logic              CLK,
   input logic              RSTN,
   inst_fetch_unit_if.slave bus
);
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_MISS} state_t;

   state_t        state, state_nx;
   logic [31:0]   fetch_pc, expect_pc;
   logic [CW-1:0] count, inflight;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [31:0]   pc_mem   [BUF_DEPTH];
   logic [31:0]   inst_mem [BUF_DEPTH];
   logic [CW:0]   occupancy;
   logic [31:0]   redirect_pc;
   logic          issue, accept, resp_ok, rsp_dec, push, pop, bypass, bypass_take;

   // A slot is reserved at issue time, so buffered + outstanding bounds the FIFO fill.
   assign occupancy   = {1'b0, count} + {1'b0, inflight};
   assign issue       = (state != S_BOOT) && !bus.FLUSH && (occupancy < DEPTH_W);
   assign accept      = issue && !bus.MEM_WAIT;
   assign resp_ok     = bus.INST_RVALID && (bus.INST_ROADDR == expect_pc) && !bus.FLUSH;
   assign rsp_dec     = bus.INST_RVALID && (inflight != '0);
   assign redirect_pc = {bus.NEW_PC[31:2], 2'b00};

   assign bus.INST_RDEN   = issue;
   assign bus.INST_RIADDR = fetch_pc;

`ifdef FETCH_BYPASS_EN
   assign bypass = resp_ok && (count == '0) && (state != S_BOOT);
`else
   assign bypass = 1'b0;
`endif

   assign bypass_take = bypass && bus.OUT_READY;
   assign push        = resp_ok && !bypass_take;
   assign pop         = (count != '0) && bus.OUT_READY && !bus.FLUSH;

   always_comb begin
      bus.OUT_VALID = (count != '0);
      bus.OUT_PC    = pc_mem[rd_ptr];
      bus.OUT_INST  = inst_mem[rd_ptr];
      if (bypass) begin
         bus.OUT_VALID = 1'b1;
         bus.OUT_PC    = bus.INST_ROADDR;
         bus.OUT_INST  = bus.INST_RDATA;
      end
   end

   // S_MISS only reports a stalled request; issue is allowed in S_RUN and S_MISS alike.
   always_comb begin
      state_nx = state;
      case (state)
         S_BOOT:  state_nx = S_RUN;
         S_RUN:   if (issue && bus.MEM_WAIT) state_nx = S_MISS;
         S_MISS:  if (!bus.MEM_WAIT) state_nx = S_RUN;
         default: state_nx = S_BOOT;
      endcase
      if (bus.FLUSH) state_nx = S_RUN;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state     <= S_BOOT;
         fetch_pc  <= START_ADDR;
         expect_pc <= START_ADDR;
         count     <= '0;
         inflight  <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else begin
         state    <= state_nx;
         inflight <= inflight + CW'(accept) - CW'(rsp_dec);
         if (bus.FLUSH) begin
            fetch_pc  <= redirect_pc;
            expect_pc <= redirect_pc;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
         end else begin
            if (accept)  fetch_pc  <= fetch_pc + 32'd4;
            if (resp_ok) expect_pc <= expect_pc + 32'd4;
            if (push) begin
               pc_mem[wr_ptr]   <= bus.INST_ROADDR;
               inst_mem[wr_ptr] <= bus.INST_RDATA;
               wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized bench for inst_fetch_unit against a queue-based MMU/decode model
module tb_inst_fetch_unit;
   localparam logic [31:0] START = 32'h0000_0100;
   localparam int          DEPTH = 4;

   logic CLK = 1'b0;
   logic RSTN = 1'b0;
   always #5 CLK = ~CLK;

   inst_fetch_unit_if bus ();
   inst_fetch_unit #(.START_ADDR(START), .BUF_DEPTH(DEPTH)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

   int n_vec = 0, n_err = 0, cyc = 0;

   logic        flush_i = 0, wait_i = 0, ready_i = 0, stray_i = 0;
   logic [31:0] new_pc_i = '0;
   int          lat_lo = 1, lat_hi = 1;

   logic [31:0] rq[$];
   int          due_q[$];
   int          last_due, m_buf;
   logic [31:0] m_req, m_exp, m_out;
   bit          m_boot;

   logic        e_rden, e_valid, g_rden, g_valid, acc, hs;
   logic [31:0] e_addr, e_pc, e_inst, g_addr, g_pc, g_inst;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      rq.delete(); due_q.delete();
      last_due = cyc; m_buf = 0;
      m_req = START; m_exp = START; m_out = START; m_boot = 1;
   endtask

   // One clock: drive MMU/decode side, predict, sample, then advance the memory-side model.
   task automatic cycle();
      logic resp, from_q;
      logic [31:0] raddr;
      int lat;
      resp = 0; from_q = 0; raddr = $urandom;
      if (rq.size() > 0 && due_q[0] <= cyc) begin resp = 1; from_q = 1; raddr = rq[0]; end
      else if (stray_i) begin resp = 1; raddr = 32'hDEAD_BEE0; end
      bus.INST_RVALID = resp; bus.INST_ROADDR = raddr; bus.INST_RDATA = mem_word(raddr);
      bus.FLUSH = flush_i; bus.NEW_PC = new_pc_i; bus.MEM_WAIT = wait_i; bus.OUT_READY = ready_i;
      e_rden  = !m_boot && !flush_i && (rq.size() + m_buf < DEPTH);
      e_valid = (m_buf != 0);
      e_addr  = m_req; e_pc = m_out; e_inst = mem_word(m_out);
      #1;
      g_rden = bus.INST_RDEN; g_addr = bus.INST_RIADDR;
      g_valid = bus.OUT_VALID; g_pc = bus.OUT_PC; g_inst = bus.OUT_INST;
      acc = g_rden && !wait_i;
      hs  = g_valid && ready_i && !flush_i;
      if (from_q) begin void'(rq.pop_front()); void'(due_q.pop_front()); end
      if (flush_i) begin
         m_req = {new_pc_i[31:2], 2'b00}; m_exp = m_req; m_out = m_req; m_buf = 0;
      end else begin
         if (hs && m_buf > 0) begin m_buf--; m_out += 4; end
         if (resp && raddr == m_exp) begin m_buf++; m_exp += 4; end
         if (acc) m_req += 4;
      end
      if (acc) begin
         lat = $urandom_range(lat_hi, lat_lo);
         last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
         rq.push_back(g_addr); due_q.push_back(last_due);
      end
      m_boot = 0;
      @(negedge CLK);
      cyc++;
   endtask

   task automatic test_reset();
      RSTN = 0;
      bus.FLUSH = 0; bus.NEW_PC = '0; bus.MEM_WAIT = 0; bus.OUT_READY = 0;
      bus.INST_RVALID = 0; bus.INST_ROADDR = '0; bus.INST_RDATA = '0;
      @(negedge CLK); #1;
      n_vec++; if (bus.INST_RDEN !== 1'b0) begin n_err++; $display("FAIL reset_rden got=%b exp=0", bus.INST_RDEN); end
      n_vec++; if (bus.INST_RIADDR !== START) begin n_err++; $display("FAIL reset_riaddr got=%h exp=%h", bus.INST_RIADDR, START); end
      n_vec++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.OUT_VALID); end
      n_vec++; if (bus.OUT_PC !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", bus.OUT_PC); end
      n_vec++; if (bus.OUT_INST !== 32'h0) begin n_err++; $display("FAIL reset_inst got=%h exp=0", bus.OUT_INST); end
      @(negedge CLK);
      model_reset();
      RSTN = 1;
   endtask

   task automatic test_stream();
      ready_i = 1; wait_i = 0; lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 30; i++) begin
         cycle();
         n_vec++; if (g_rden !== e_rden) begin n_err++; $display("FAIL stream_rden cyc=%0d got=%b exp=%b", cyc, g_rden, e_rden); end
         n_vec++; if (g_addr !== e_addr) begin n_err++; $display("FAIL stream_addr cyc=%0d got=%h exp=%h", cyc, g_addr, e_addr); end
         n_vec++; if (g_valid !== e_valid) begin n_err++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, g_valid, e_valid); end
         if (hs) begin
            n_vec++; if (g_pc !== e_pc || g_inst !== e_inst) begin n_err++; $display("FAIL stream_data cyc=%0d got=%h/%h exp=%h/%h", cyc, g_pc, g_inst, e_pc, e_inst); end
         end
         if (i >= 3) begin
            n_vec++; if (g_valid !== 1'b1) begin n_err++; $display("FAIL stream_gap cyc=%0d got=%b exp=1", cyc, g_valid); end
         end
      end
   endtask

   task automatic test_miss();
      int n_acc = 0, n_hs = 0;
      ready_i = 1; lat_lo = 1; lat_hi = 1;
      flush_i = 1; new_pc_i = 32'h200; cycle(); flush_i = 0;
      wait_i = 1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         n_vec++; if (g_rden !== 1'b1 || g_addr !== 32'h200) begin n_err++; $display("FAIL miss_hold cyc=%0d got=%b/%h exp=1/00000200", cyc, g_rden, g_addr); end
      end
      wait_i = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (acc && g_addr == 32'h200) n_acc++;
         if (hs) begin
            n_vec++; if (g_pc !== 32'h200 + 4 * n_hs || g_inst !== mem_word(32'h200 + 4 * n_hs)) begin
               n_err++; $display("FAIL miss_out cyc=%0d got=%h/%h exp=%h", cyc, g_pc, g_inst, 32'h200 + 4 * n_hs); end
            n_hs++;
         end
      end
      n_vec++; if (n_acc != 1) begin n_err++; $display("FAIL miss_accepts got=%0d exp=1", n_acc); end
      n_vec++; if (n_hs < 2) begin n_err++; $display("FAIL miss_timeout got=%0d outputs exp>=2", n_hs); end
   endtask

   task automatic test_backpressure();
      int n_acc = 0;
      ready_i = 0; wait_i = 0; lat_lo = 1; lat_hi = 3;
      flush_i = 1; new_pc_i = 32'h300; cycle(); flush_i = 0;
      for (int i = 0; i < 14; i++) begin
         cycle();
         if (acc) n_acc++;
         n_vec++; if (g_rden !== e_rden) begin n_err++; $display("FAIL bp_rden cyc=%0d got=%b exp=%b", cyc, g_rden, e_rden); end
      end
      n_vec++; if (n_acc != DEPTH) begin n_err++; $display("FAIL bp_accepts got=%0d exp=%0d", n_acc, DEPTH); end
      n_vec++; if (g_rden !== 1'b0) begin n_err++; $display("FAIL bp_stall got=%b exp=0", g_rden); end
      n_vec++; if (g_valid !== 1'b1 || g_pc !== 32'h300) begin n_err++; $display("FAIL bp_head got=%b/%h exp=1/00000300", g_valid, g_pc); end
      ready_i = 1;
      for (int i = 0; i < 25; i++) begin
         cycle();
         n_vec++; if (g_rden !== e_rden) begin n_err++; $display("FAIL bp_resume_rden cyc=%0d got=%b exp=%b", cyc, g_rden, e_rden); end
         n_vec++; if (g_valid !== e_valid) begin n_err++; $display("FAIL bp_resume_valid cyc=%0d got=%b exp=%b", cyc, g_valid, e_valid); end
         if (hs) begin
            n_vec++; if (g_pc !== e_pc || g_inst !== e_inst) begin n_err++; $display("FAIL bp_data cyc=%0d got=%h/%h exp=%h/%h", cyc, g_pc, g_inst, e_pc, e_inst); end
         end
      end
   endtask

   task automatic test_flush();
      bit seen;
      ready_i = 1; wait_i = 0; lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 8; i++) cycle();
      flush_i = 1; new_pc_i = 32'h1003; cycle(); flush_i = 0;
      n_vec++; if (g_rden !== 1'b0) begin n_err++; $display("FAIL flush_rden got=%b exp=0", g_rden); end
      cycle();
      n_vec++; if (g_rden !== 1'b1 || g_addr !== 32'h1000) begin n_err++; $display("FAIL flush_req got=%b/%h exp=1/00001000", g_rden, g_addr); end
      n_vec++; if (g_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty got=%b exp=0", g_valid); end
      seen = 0;
      for (int i = 0; i < 15 && !seen; i++) begin
         cycle();
         if (hs) begin
            seen = 1;
            n_vec++; if (g_pc !== 32'h1000 || g_inst !== mem_word(32'h1000)) begin n_err++; $display("FAIL flush_first got=%h/%h exp=00001000", g_pc, g_inst); end
         end
      end
      n_vec++; if (!seen) begin n_err++; $display("FAIL flush_timeout got=none exp=output"); end
      flush_i = 1; new_pc_i = 32'h2000; cycle();
      new_pc_i = 32'h3000; cycle(); flush_i = 0;
      seen = 0;
      for (int i = 0; i < 15 && !seen; i++) begin
         cycle();
         if (hs) begin
            seen = 1;
            n_vec++; if (g_pc !== 32'h3000) begin n_err++; $display("FAIL b2b_flush got=%h exp=00003000", g_pc); end
         end
      end
      n_vec++; if (!seen) begin n_err++; $display("FAIL b2b_timeout got=none exp=output"); end
   endtask

   task automatic test_stray();
      ready_i = 0; wait_i = 0; lat_lo = 1; lat_hi = 1;
      flush_i = 1; new_pc_i = 32'h400; cycle(); flush_i = 0;
      for (int i = 0; i < 10; i++) cycle();
      stray_i = 1; cycle(); stray_i = 0;
      n_vec++; if (g_rden !== 1'b0 || g_valid !== 1'b1 || g_pc !== 32'h400) begin n_err++; $display("FAIL stray_state got=%b/%b/%h exp=0/1/00000400", g_rden, g_valid, g_pc); end
      cycle();
      n_vec++; if (g_rden !== 1'b0 || g_pc !== 32'h400) begin n_err++; $display("FAIL stray_after got=%b/%h exp=0/00000400", g_rden, g_pc); end
      ready_i = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         n_vec++; if (g_rden !== e_rden) begin n_err++; $display("FAIL stray_rden cyc=%0d got=%b exp=%b", cyc, g_rden, e_rden); end
         if (hs) begin
            n_vec++; if (g_pc !== e_pc) begin n_err++; $display("FAIL stray_data cyc=%0d got=%h exp=%h", cyc, g_pc, e_pc); end
         end
      end
   endtask

   task automatic test_wrap();
      bit seen_zero = 0;
      ready_i = 1; wait_i = 0; lat_lo = 1; lat_hi = 2;
      flush_i = 1; new_pc_i = 32'hFFFF_FFF4; cycle(); flush_i = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         n_vec++; if (g_addr !== e_addr) begin n_err++; $display("FAIL wrap_addr cyc=%0d got=%h exp=%h", cyc, g_addr, e_addr); end
         if (hs) begin
            if (g_pc == 32'h0) seen_zero = 1;
            n_vec++; if (g_pc !== e_pc || g_inst !== e_inst) begin n_err++; $display("FAIL wrap_data cyc=%0d got=%h/%h exp=%h/%h", cyc, g_pc, g_inst, e_pc, e_inst); end
         end
      end
      n_vec++; if (!seen_zero) begin n_err++; $display("FAIL wrap_zero got=0 exp=1"); end
   endtask

   task automatic test_random();
      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 300; i++) begin
         wait_i  = ($urandom_range(3, 0) == 0);
         ready_i = ($urandom_range(9, 0) < 7);
         flush_i = ($urandom_range(31, 0) == 0);
         new_pc_i = {4'h4, 28'($urandom)};
         cycle();
         n_vec++; if (g_rden !== e_rden) begin n_err++; $display("FAIL rand_rden cyc=%0d got=%b exp=%b", cyc, g_rden, e_rden); end
         n_vec++; if (g_addr !== e_addr) begin n_err++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, g_addr, e_addr); end
         n_vec++; if (g_valid !== e_valid) begin n_err++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, g_valid, e_valid); end
         if (hs) begin
            n_vec++; if (g_pc !== e_pc || g_inst !== e_inst) begin n_err++; $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h", cyc, g_pc, g_inst, e_pc, e_inst); end
         end
      end
      flush_i = 0; wait_i = 0;
   endtask

   task automatic test_reset_mid_miss();
      ready_i = 0; wait_i = 0; lat_lo = 1; lat_hi = 1;
      flush_i = 1; new_pc_i = 32'h500; cycle(); flush_i = 0;
      for (int i = 0; i < 3; i++) cycle();
      wait_i = 1; cycle(); cycle();
      n_vec++; if (g_rden !== 1'b1 || g_valid !== 1'b1) begin n_err++; $display("FAIL premiss got=%b/%b exp=1/1", g_rden, g_valid); end
      #2; RSTN = 0; #1;
      n_vec++; if (bus.INST_RDEN !== 1'b0) begin n_err++; $display("FAIL async_rden got=%b exp=0", bus.INST_RDEN); end
      n_vec++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL async_valid got=%b exp=0", bus.OUT_VALID); end
      n_vec++; if (bus.INST_RIADDR !== START) begin n_err++; $display("FAIL async_addr got=%h exp=%h", bus.INST_RIADDR, START); end
      @(negedge CLK);
      model_reset();
      wait_i = 0; ready_i = 1;
      RSTN = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         n_vec++; if (g_rden !== e_rden || g_addr !== e_addr) begin n_err++; $display("FAIL restart cyc=%0d got=%b/%h exp=%b/%h", cyc, g_rden, g_addr, e_rden, e_addr); end
         if (hs) begin
            n_vec++; if (g_pc !== e_pc) begin n_err++; $display("FAIL restart_data cyc=%0d got=%h exp=%h", cyc, g_pc, e_pc); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_miss();
      test_backpressure();
      test_flush();
      test_stray();
      test_wrap();
      test_random();
      test_reset_mid_miss();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
